// File: rtl/bundle_encoder.sv
// Purpose: bind level HVs to feature position by rotation, bundle into per-dimension counters, threshold into a query HV.
// Latency: start edge T -> encoding_done set at edge T+CHUNKS+1 (plus any en-low cycles).
// Backpressure: none; en=0 freezes all state, start while busy is ignored, level_hvs must hold while busy.
module bundle_encoder #(
    parameter int HV_DIM          = 1024,
    parameter int FEATURE_COUNT   = 40,
    parameter int FEATURES_PER_CC = 4,
    parameter int CHUNKS          = FEATURE_COUNT / FEATURES_PER_CC,
    parameter int CNT_W           = $clog2(FEATURE_COUNT + 1)
) (
    input  logic                                    clk,
    input  logic                                    nrst,
    input  logic                                    en,
    input  logic                                    start_encoding,
    input  logic [FEATURE_COUNT-1:0][HV_DIM-1:0]    level_hvs,
    input  logic [CNT_W-1:0]                        threshold,
    output logic                                    busy,
    output logic                                    encoding_done,
    output logic [HV_DIM-1:0]                       query_hv
);

    localparam int CTR_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        THRESH = 2'd2
    } state_t;

    state_t                              state_q, state_d;
    logic [CTR_W-1:0]                    ctr_q, ctr_d;
    logic [HV_DIM-1:0][CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]                    thr_q, thr_d;
    logic [HV_DIM-1:0]                   query_q, query_d;
    logic                                done_q, done_d;

    // Rotations are by constant feature index, so they are pure wiring;
    // regrouping by chunk lets the chunk counter pick one slice directly.
    logic [CHUNKS-1:0][FEATURES_PER_CC-1:0][HV_DIM-1:0] rot_hvs;
    logic [FEATURES_PER_CC-1:0][HV_DIM-1:0]             chunk_hvs;
    logic [HV_DIM-1:0][CNT_W-1:0]                       cnt_acc;
    logic [HV_DIM-1:0]                                  cnt_ge;

    for (genvar f = 0; f < FEATURE_COUNT; f++) begin : g_rot
        if (f == 0) begin : g_plain
            assign rot_hvs[0][0] = level_hvs[0];
        end else begin : g_rotl
            assign rot_hvs[f / FEATURES_PER_CC][f % FEATURES_PER_CC] =
                {level_hvs[f][HV_DIM-1-f:0], level_hvs[f][HV_DIM-1:HV_DIM-f]};
        end
    end

    assign chunk_hvs = rot_hvs[ctr_q];

    // Per dimension: add this chunk's bits to the counter, and compare the counter to the threshold.
    for (genvar d = 0; d < HV_DIM; d++) begin : g_dim
        logic [FEATURES_PER_CC-1:0] col;
        for (genvar k = 0; k < FEATURES_PER_CC; k++) begin : g_col
            assign col[k] = chunk_hvs[k][d];
        end
        assign cnt_acc[d] = cnt_q[d] + CNT_W'($countones(col));
        assign cnt_ge[d]  = (cnt_q[d] >= thr_q);
    end

    // Next-state logic; with en low everything holds and the done pulse drops.
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        cnt_d   = cnt_q;
        thr_d   = thr_q;
        query_d = query_q;
        done_d  = 1'b0;
        if (en) begin
            case (state_q)
                IDLE: begin
                    if (start_encoding) begin
                        cnt_d   = '0;
                        thr_d   = threshold;
                        ctr_d   = '0;
                        state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    cnt_d = cnt_acc;
                    if (ctr_q == CTR_W'(CHUNKS - 1)) begin
                        ctr_d   = '0;
                        state_d = THRESH;
                    end else begin
                        ctr_d = ctr_q + 1'b1;
                    end
                end
                THRESH: begin
                    query_d = cnt_ge;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State registers with synchronous active-low reset that aborts any encode in progress.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
            ctr_q   <= '0;
            cnt_q   <= '0;
            thr_q   <= '0;
            query_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            cnt_q   <= cnt_d;
            thr_q   <= thr_d;
            query_q <= query_d;
            done_q  <= done_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign encoding_done = done_q;
    assign query_hv      = query_q;

endmodule

// File: tb/tb_bundle_encoder.sv
// Purpose: directed and randomized checks of bundle_encoder against a counting reference model.
// Latency: expects done 11 edges after start with default parameters.
// Backpressure: exercises en gaps, ignored starts, mid-encode reset and back-to-back starts.
module tb_bundle_encoder;

    localparam int HV = 1024;
    localparam int FC = 40;
    localparam int CW = 6;

    typedef logic [FC-1:0][HV-1:0] lvl_t;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          en = 1'b0;
    logic          start = 1'b0;
    lvl_t          lvl = '0;
    logic [CW-1:0] thr = '0;
    logic          busy;
    logic          encoding_done;
    logic [HV-1:0] query_hv;

    int total = 0;
    int passed = 0;
    int fails = 0;

    bundle_encoder dut (
        .clk            (clk),
        .nrst           (nrst),
        .en             (en),
        .start_encoding (start),
        .level_hvs      (lvl),
        .threshold      (thr),
        .busy           (busy),
        .encoding_done  (encoding_done),
        .query_hv       (query_hv)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: count, per output dimension, how many features land a one there after rotation.
    function automatic logic [HV-1:0] model(input lvl_t l, input int t);
        logic [HV-1:0] q;
        int cnt;
        q = '0;
        for (int d = 0; d < HV; d++) begin
            cnt = 0;
            for (int f = 0; f < FC; f++)
                if (l[f][(d - f + HV) % HV]) cnt++;
            q[d] = (cnt >= t);
        end
        return q;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_hv(input string tag, input logic [HV-1:0] obs, input logic [HV-1:0] exp);
        logic [63:0] ol;
        logic [63:0] el;
        ol = obs[63:0];
        el = exp[63:0];
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed ones=%0d low64=%h expected ones=%0d low64=%h",
                   tag, $countones(obs), ol, $countones(exp), el);
        end
    endtask

    // Steps until encoding_done, counting steps and busy-high samples; bounded.
    task automatic wait_done(output int n, output int nb);
        n = 0;
        nb = 0;
        while (encoding_done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) nb++;
            step();
            n++;
        end
    endtask

    task automatic run_encode(input string tag, input int thr_v, input logic [HV-1:0] exp);
        int n;
        int nb;
        thr = CW'(thr_v);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(n, nb);
        chk_int({tag, " latency"}, n, 11);
        chk_int({tag, " busy cycles"}, nb, 11);
        chk_hv({tag, " query"}, query_hv, exp);
        chk_bit({tag, " busy at done"}, busy, 1'b0);
        step();
        chk_bit({tag, " pulse width"}, encoding_done, 1'b0);
    endtask

    task automatic randomize_lvl();
        for (int f = 0; f < FC; f++)
            for (int w = 0; w < HV / 32; w++)
                lvl[f][w*32 +: 32] = $urandom();
    endtask

    logic [HV-1:0] exp_q;
    logic [HV-1:0] prev_q;
    int n;
    int nb;
    int cnt;

    initial begin
        // Reset state
        nrst = 1'b0;
        step();
        step();
        chk_bit("reset busy", busy, 1'b0);
        chk_bit("reset done", encoding_done, 1'b0);
        chk_hv("reset query", query_hv, '0);
        nrst = 1'b1;
        en = 1'b1;
        step();

        // All-zero inputs
        lvl = '0;
        run_encode("zeros thr1", 1, '0);

        // Single bit 0 per feature: rotation spreads them to bits 0..FC-1
        for (int f = 0; f < FC; f++) lvl[f] = '0;
        for (int f = 0; f < FC; f++) lvl[f][0] = 1'b1;
        exp_q = '0;
        for (int i = 0; i < FC; i++) exp_q[i] = 1'b1;
        run_encode("bit0 thr1", 1, exp_q);
        run_encode("bit0 thr2", 2, '0);

        // Saturated inputs and threshold boundaries
        lvl = '1;
        run_encode("ones thr40", 40, '1);
        run_encode("ones thr41", 41, '0);
        lvl = '0;
        run_encode("zeros thr0", 0, '1);

        // Random inputs, en gap at ctr=4, threshold changed after start
        randomize_lvl();
        exp_q = model(lvl, 20);
        thr = CW'(20);
        start = 1'b1;
        step();
        start = 1'b0;
        thr = '0;
        for (int i = 0; i < 4; i++) step();
        en = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (encoding_done === 1'b1) cnt++;
        end
        chk_int("en gap done pulses", cnt, 0);
        chk_bit("en gap busy", busy, 1'b1);
        en = 1'b1;
        wait_done(n, nb);
        chk_int("en gap latency", n, 7);
        chk_hv("random thr20 query", query_hv, exp_q);
        prev_q = query_hv;
        step();
        chk_bit("en gap pulse width", encoding_done, 1'b0);

        // Reset at ctr=5 with a nonzero previous query
        chk_bit("prev query nonzero", (prev_q != '0), 1'b1);
        randomize_lvl();
        thr = CW'(15);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        chk_bit("abort busy", busy, 1'b0);
        chk_bit("abort done", encoding_done, 1'b0);
        chk_hv("abort query", query_hv, '0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (encoding_done === 1'b1) cnt++;
        end
        chk_int("abort no done", cnt, 0);
        run_encode("after abort thr15", 15, model(lvl, 15));

        // Starts while busy (ctr=3 and THRESH) are ignored
        randomize_lvl();
        exp_q = model(lvl, 18);
        thr = CW'(18);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        start = 1'b1;
        step();
        start = 1'b0;
        chk_bit("busy-start done", encoding_done, 1'b1);
        chk_hv("busy-start query", query_hv, exp_q);
        prev_q = exp_q;

        // Back-to-back: start in the done cycle
        randomize_lvl();
        thr = CW'(22);
        exp_q = model(lvl, 22);
        start = 1'b1;
        step();
        start = 1'b0;
        chk_bit("thresh-start ignored pulse", encoding_done, 1'b0);
        chk_bit("b2b accepted busy", busy, 1'b1);
        chk_hv("b2b first query held", query_hv, prev_q);
        wait_done(n, nb);
        chk_int("b2b latency", n, 11);
        chk_hv("b2b second query", query_hv, exp_q);
        step();
        chk_bit("b2b pulse width", encoding_done, 1'b0);
        chk_bit("b2b idle", busy, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
